// File: rtl/bus_command_master_if.sv
// Command-master handshake bundle: the UART byte streams plus the register-bus
// address/control lines. The 32-bit databus is a bidirectional net and is
// carried as a separate inout port on the master.
interface bus_command_master_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] reg_size;
  logic [7:0] register_addr;
  logic       rw;
  logic       select;

  modport master (
    input  rx_data, rx_valid, tx_ready, reg_size,
    output tx_data, tx_valid, register_addr, rw, select
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_size,
    input  tx_data, tx_valid, register_addr, rw, select
  );
endinterface

// File: rtl/bus_command_master.sv
// Upstream register-bus master. Parses framed write/read command packets from
// the UART receive stream, runs one register cycle on the shared peripheral
// bus per packet, and streams the reply back to the UART transmitter.
module bus_command_master #(
  parameter int unsigned SELECT_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                clk_12MHz,
  input  logic                reset,
  bus_command_master_if.master bus,
  inout  wire  [31:0]         databus,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned SelW   = $clog2(SELECT_CYCLES + 1);
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspAck   = 8'h06;
  localparam logic [7:0] RspErr   = 8'hEE;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StBusSetup,
    StBusSel,
    StBusHold,
    StTxSize,
    StTxData,
    StTxAck,
    StTxErr
  } state_e;

  state_e              r_state;
  logic                r_is_write;
  logic [7:0]          r_addr;
  logic [2:0]          r_len;
  logic [2:0]          r_cnt;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [2:0]          r_size;
  logic [2:0]          r_count;
  logic [2:0]          r_tx_cnt;
  logic [TimerW-1:0]   r_timer;
  logic [SelW-1:0]     r_sel_cnt;
  logic                r_select;
  logic                r_rw;
  logic [7:0]          r_reg_addr;
  logic                r_drive;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_busy;
  logic                r_overrun;

  logic w_rx_state;
  logic w_timeout;
  logic w_tx_fire;
  logic w_sel_last;

  // Packet-parsing states accept rx bytes; everywhere else they are dropped.
  assign w_rx_state = (r_state == StIdle) || (r_state == StAddr) ||
                      (r_state == StLen)  || (r_state == StData);
  assign w_timeout  = (r_timer == TimerW'(TIMEOUT_CYCLES - 1));
  assign w_tx_fire  = r_tx_valid & bus.tx_ready;
  assign w_sel_last = (r_sel_cnt == SelW'(SELECT_CYCLES - 1));

  assign bus.register_addr = r_reg_addr;
  assign bus.rw            = r_rw;
  assign bus.select        = r_select;
  assign bus.tx_data       = r_tx_data;
  assign bus.tx_valid      = r_tx_valid;
  assign busy              = r_busy;
  assign overrun           = r_overrun;

  // Write data is on the bus from BUS_SETUP through the last BUS_SEL cycle.
  assign databus = r_drive ? r_wdata : 'z;

  // Packet parser, bus cycle sequencer and reply streamer with registered outputs.
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      r_state    <= StIdle;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_size     <= '0;
      r_count    <= '0;
      r_tx_cnt   <= '0;
      r_timer    <= '0;
      r_sel_cnt  <= '0;
      r_select   <= 1'b0;
      r_rw       <= 1'b1;
      r_reg_addr <= '0;
      r_drive    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= bus.rx_valid & ~w_rx_state;

      case (r_state)
        StIdle: begin
          // Unknown command bytes are ignored without flagging overrun.
          if (bus.rx_valid && (bus.rx_data == CmdWrite || bus.rx_data == CmdRead)) begin
            r_is_write <= (bus.rx_data == CmdWrite);
            r_timer    <= '0;
            r_busy     <= 1'b1;
            r_state    <= StAddr;
          end
        end

        StAddr: begin
          if (bus.rx_valid) begin
            r_timer <= '0;
            r_addr  <= bus.rx_data;
            if (r_is_write) begin
              r_state <= StLen;
            end else begin
              r_reg_addr <= bus.rx_data;
              r_rw       <= 1'b1;
              r_state    <= StBusSetup;
            end
          end else if (w_timeout) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end

        StLen: begin
          if (bus.rx_valid) begin
            r_timer <= '0;
            if (bus.rx_data >= 8'd1 && bus.rx_data <= 8'd4) begin
              r_len   <= bus.rx_data[2:0];
              r_cnt   <= '0;
              r_wdata <= '0;
              r_state <= StData;
            end else begin
              r_tx_data  <= RspErr;
              r_tx_valid <= 1'b1;
              r_state    <= StTxErr;
            end
          end else if (w_timeout) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end

        StData: begin
          if (bus.rx_valid) begin
            r_timer                               <= '0;
            r_wdata[{r_cnt[1:0], 3'b000} +: 8]    <= bus.rx_data;
            r_cnt                                 <= r_cnt + 3'd1;
            if (r_cnt == r_len - 3'd1) begin
              r_reg_addr <= r_addr;
              r_rw       <= 1'b0;
              r_drive    <= 1'b1;
              r_state    <= StBusSetup;
            end
          end else if (w_timeout) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end

        StBusSetup: begin
          r_select  <= 1'b1;
          r_sel_cnt <= '0;
          r_state   <= StBusSel;
        end

        StBusSel: begin
          if (w_sel_last) begin
            // Read data and size are captured on the last cycle select is high.
            r_select <= 1'b0;
            r_drive  <= 1'b0;
            if (!r_is_write) begin
              r_rdata <= databus;
              r_size  <= bus.reg_size;
              r_count <= (bus.reg_size > 3'd4) ? 3'd4 : bus.reg_size;
            end
            r_state <= StBusHold;
          end else begin
            r_sel_cnt <= r_sel_cnt + SelW'(1);
          end
        end

        StBusHold: begin
          r_rw       <= 1'b1;
          r_tx_valid <= 1'b1;
          if (r_is_write) begin
            r_tx_data <= RspAck;
            r_state   <= StTxAck;
          end else begin
            r_tx_data <= {5'b0, r_size};
            r_state   <= StTxSize;
          end
        end

        StTxSize: begin
          if (w_tx_fire) begin
            if (r_count == 3'd0) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= StIdle;
            end else begin
              r_tx_data <= r_rdata[7:0];
              r_tx_cnt  <= 3'd1;
              r_state   <= StTxData;
            end
          end
        end

        StTxData: begin
          if (w_tx_fire) begin
            if (r_tx_cnt == r_count) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= StIdle;
            end else begin
              r_tx_data <= r_rdata[{r_tx_cnt[1:0], 3'b000} +: 8];
              r_tx_cnt  <= r_tx_cnt + 3'd1;
            end
          end
        end

        StTxAck, StTxErr: begin
          if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= StIdle;
          end
        end

        default: begin
          r_select   <= 1'b0;
          r_drive    <= 1'b0;
          r_rw       <= 1'b1;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_command_master.sv
// Directed bench for bus_command_master: writes, reads with size clamping,
// bad length, garbage and timeout, backpressure with overrun, and reset
// in the middle of a bus cycle.
module tb_bus_command_master;

  localparam int unsigned SelCycles = 4;
  localparam int unsigned Timeout   = 1000;

  logic        clk_12MHz = 1'b0;
  logic        reset;
  logic        busy;
  logic        overrun;
  logic [31:0] periph_data;
  wire  [31:0] databus;

  bus_command_master_if bus_if ();

  bus_command_master #(
    .SELECT_CYCLES  (SelCycles),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .bus       (bus_if),
    .databus   (databus),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  // Peripheral model: drives read data while a read cycle is selected.
  assign databus = (bus_if.select && bus_if.rw) ? periph_data : 'z;

  int n_vec  = 0;
  int n_miss = 0;

  // Monitor state, written only by the monitor process.
  logic        prev_sel = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          sel_rises = 0;
  int          sel_cycles = 0;
  int          sel_unstable = 0;
  int          hold_viol = 0;
  int          ovr_cnt = 0;
  logic [7:0]  last_addr = 8'h00;
  logic        last_rw = 1'b1;
  logic [31:0] last_data = 32'h0;
  logic [7:0]  tx_q[$];

  // Sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk_12MHz) begin
    prev_sel   <= bus_if.select;
    prev_valid <= bus_if.tx_valid;
    prev_ready <= bus_if.tx_ready;
    prev_data  <= bus_if.tx_data;
    if (!reset) begin
      if (bus_if.select) begin
        sel_cycles <= sel_cycles + 1;
        if (!prev_sel) begin
          sel_rises <= sel_rises + 1;
          last_addr <= bus_if.register_addr;
          last_rw   <= bus_if.rw;
          last_data <= databus;
        end else if (bus_if.register_addr != last_addr || bus_if.rw != last_rw ||
                     databus != last_data) begin
          sel_unstable <= sel_unstable + 1;
        end
      end
      if (bus_if.tx_valid && bus_if.tx_ready) tx_q.push_back(bus_if.tx_data);
      if (prev_valid && !prev_ready && (!bus_if.tx_valid || bus_if.tx_data != prev_data))
        hold_viol <= hold_viol + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12MHz);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    tick();
    bus_if.rx_valid = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    tick();
  endtask

  // Write of len bytes taken LSB first from word; expects one select pulse and an ACK.
  task automatic do_write(input string tag, input logic [7:0] addr, input int len,
                          input logic [31:0] word);
    int          rise0 = sel_rises;
    int          cyc0  = sel_cycles;
    int          uns0  = sel_unstable;
    int          base  = tx_q.size();
    logic [31:0] exp_w = 32'h0;
    send_byte(8'h57);
    send_byte(addr);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      send_byte(word[8*i +: 8]);
      exp_w[8*i +: 8] = word[8*i +: 8];
    end
    wait_idle({tag, "_idle"}, 200);
    check({tag, "_sel_rises"}, 32'(sel_rises - rise0), 32'd1);
    check({tag, "_sel_cycles"}, 32'(sel_cycles - cyc0), 32'(SelCycles));
    check({tag, "_sel_stable"}, 32'(sel_unstable - uns0), 32'd0);
    check({tag, "_rw"}, 32'(last_rw), 32'd0);
    check({tag, "_addr"}, 32'(last_addr), 32'(addr));
    check({tag, "_databus"}, last_data, exp_w);
    check({tag, "_tx_count"}, 32'(tx_q.size() - base), 32'd1);
    check({tag, "_ack"}, 32'(tx_q[base]), 32'h06);
  endtask

  // Read with the peripheral answering size/data; reply is the raw size then the
  // clamped number of data bytes, LSB first.
  task automatic do_read(input string tag, input logic [7:0] addr, input logic [2:0] size,
                         input logic [31:0] word);
    int rise0 = sel_rises;
    int cyc0  = sel_cycles;
    int base  = tx_q.size();
    int cnt   = (size > 3'd4) ? 4 : int'(size);
    periph_data     = word;
    bus_if.reg_size = size;
    send_byte(8'h52);
    send_byte(addr);
    wait_idle({tag, "_idle"}, 200);
    check({tag, "_sel_rises"}, 32'(sel_rises - rise0), 32'd1);
    check({tag, "_sel_cycles"}, 32'(sel_cycles - cyc0), 32'(SelCycles));
    check({tag, "_rw"}, 32'(last_rw), 32'd1);
    check({tag, "_addr"}, 32'(last_addr), 32'(addr));
    check({tag, "_tx_count"}, 32'(tx_q.size() - base), 32'(1 + cnt));
    check({tag, "_size"}, 32'(tx_q[base]), {29'd0, size});
    for (int i = 0; i < cnt; i++)
      check({tag, "_byte"}, 32'(tx_q[base + 1 + i]), 32'(word[8*i +: 8]));
  endtask

  initial begin
    int base;
    int ovr0;
    int rise0;
    int n;

    reset           = 1'b1;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b1;
    bus_if.reg_size = 3'd0;
    periph_data     = 32'h0;
    repeat (3) tick();

    check("rst_select", 32'(bus_if.select), 32'd0);
    check("rst_rw", 32'(bus_if.rw), 32'd1);
    check("rst_addr", 32'(bus_if.register_addr), 32'd0);
    check("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus_if.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    do_write("wr1", 8'h00, 1, 32'h0000002A);
    do_read("rd1", 8'h03, 3'd4, 32'h12345678);
    do_write("wr3", 8'h10, 3, 32'hAA332211);
    do_read("rd_size0", 8'h20, 3'd0, 32'hDEADBEEF);
    do_read("rd_size7", 8'h21, 3'd7, 32'h87654321);

    // Bad length: error reply and no bus cycle.
    rise0 = sel_rises;
    base  = tx_q.size();
    send_byte(8'h57);
    send_byte(8'h02);
    send_byte(8'h05);
    wait_idle("badlen_idle", 50);
    check("badlen_no_sel", 32'(sel_rises - rise0), 32'd0);
    check("badlen_tx_count", 32'(tx_q.size() - base), 32'd1);
    check("badlen_err", 32'(tx_q[base]), 32'hEE);

    // Garbage byte is dropped silently in IDLE.
    ovr0 = ovr_cnt;
    send_byte(8'h41);
    check("garbage_busy", 32'(busy), 32'd0);
    check("garbage_overrun", 32'(ovr_cnt - ovr0), 32'd0);

    // Stalled packet times out with no bus cycle and no reply.
    rise0 = sel_rises;
    base  = tx_q.size();
    send_byte(8'h57);
    send_byte(8'h03);
    check("timeout_busy_start", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 2 * Timeout) begin
      tick();
      n++;
    end
    check("timeout_window", 32'(n >= 990 && n <= 1010), 32'd1);
    check("timeout_no_sel", 32'(sel_rises - rise0), 32'd0);
    check("timeout_no_tx", 32'(tx_q.size() - base), 32'd0);
    do_read("rd_after_to", 8'h01, 3'd2, 32'hCAFEF00D);

    // Backpressure: size byte held stable while the transmitter stalls.
    base             = tx_q.size();
    bus_if.tx_ready  = 1'b0;
    periph_data      = 32'h12345678;
    bus_if.reg_size  = 3'd4;
    send_byte(8'h52);
    send_byte(8'h05);
    n = 0;
    while (!bus_if.tx_valid && n < 40) begin
      tick();
      n++;
    end
    repeat (50) tick();
    check("bp_tx_valid", 32'(bus_if.tx_valid), 32'd1);
    check("bp_tx_data", 32'(bus_if.tx_data), 32'h04);
    check("bp_hold", 32'(hold_viol), 32'd0);
    check("bp_no_tx", 32'(tx_q.size() - base), 32'd0);

    // Release, then push an rx byte while data bytes are streaming.
    ovr0            = ovr_cnt;
    bus_if.tx_ready = 1'b1;
    n = 0;
    while (tx_q.size() < base + 2 && n < 20) begin
      tick();
      n++;
    end
    send_byte(8'h99);
    wait_idle("bp_idle", 50);
    check("bp_overrun", 32'(ovr_cnt - ovr0), 32'd1);
    check("bp_tx_count", 32'(tx_q.size() - base), 32'd5);
    check("bp_b0", 32'(tx_q[base]), 32'h04);
    check("bp_b1", 32'(tx_q[base + 1]), 32'h78);
    check("bp_b2", 32'(tx_q[base + 2]), 32'h56);
    check("bp_b3", 32'(tx_q[base + 3]), 32'h34);
    check("bp_b4", 32'(tx_q[base + 4]), 32'h12);

    // Reset in the middle of a write bus cycle.
    rise0 = sel_rises;
    base  = tx_q.size();
    send_byte(8'h57);
    send_byte(8'h07);
    send_byte(8'h01);
    send_byte(8'h55);
    n = 0;
    while (!bus_if.select && n < 10) begin
      tick();
      n++;
    end
    check("mid_sel_seen", 32'(bus_if.select), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_select", 32'(bus_if.select), 32'd0);
    check("mid_rst_rw", 32'(bus_if.rw), 32'd1);
    check("mid_rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_databus", 32'(databus === 32'h00000055), 32'd0);
    reset = 1'b0;
    repeat (20) tick();
    check("mid_no_reply", 32'(tx_q.size() - base), 32'd0);
    check("mid_busy_after", 32'(busy), 32'd0);
    check("mid_one_sel", 32'(sel_rises - rise0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
